serdes_frame_aligner: RTL and testbench
=======================================

// Module: serdes_frame_aligner
// PURPOSE
//  Downstream of the SerDes top: consumes its 32-bit recovered words, which carry
//  arbitrary bit slip, and finds frame alignment by hunting for SYNC_WORD.
//  Emits bit-aligned 32-bit words with start-of-frame and lock status.
//  Frame = FRAME_LEN words; word 0 of every frame is SYNC_WORD.
// PARAMETERS
//  SYNC_WORD  32'hF6F6_2828  framing pattern, first word of each frame
//  FRAME_LEN  8              words per frame incl. sync word, >=2
//  LOCK_CNT   3              consecutive good syncs at one offset to declare lock
//  LOSS_CNT   2              consecutive bad syncs while LOCKED to drop lock
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   synchronous reset, active-low
//  din        in   32  raw word from SerDes data_out, MSB first in time
//  din_valid  in   1   din qualifier; all state holds when low
//  dout       out  32  aligned word
//  dout_valid out  1   dout qualifier
//  dout_sof   out  1   dout is the frame's sync word, only with dout_valid
//  locked     out  1   state==LOCKED
//  offset     out  5   captured bit offset k
//  err_cnt    out  16  sync-miss counter (see CONFIGURATION)
// BEHAVIOUR
//  - rst==0 at edge: every output 0, state=HUNT, all counters 0, prev_ok=0.
//  - On din_valid: prev<=din; prev_ok<=1. Window w={prev,din} (64b).
//    Candidate k in 0..31: cand(k)=w[31+k:k]. k=0 is din itself.
//  - No sync checks while prev_ok==0; first valid word after reset only loads prev.
//  - Word counter wc, mod FRAME_LEN, advances on each valid word once out of HUNT.
//    Boundary: word with wc==0 is checked against SYNC_WORD at stored offset.
//  - HUNT: lowest k with cand(k)==SYNC_WORD wins. On match: offset<=k, wc<=1,
//    hits<=1, ->CONFIRM (LOCK_CNT==1 -> LOCKED directly). No match: stay.
//  - CONFIRM: at boundary, match -> hits++; if hits reaches LOCK_CNT -> LOCKED.
//    Mismatch -> HUNT, hits<=0; that same word is NOT re-hunted.
//  - LOCKED: at boundary, match -> miss<=0; mismatch -> miss++;
//    miss reaches LOSS_CNT -> HUNT. Non-boundary words never checked.
//  - Output latency 1 cycle: registered from the din_valid word.
//    dout=cand(offset). dout_valid=1 iff the word is processed in LOCKED
//    or is the sync word that completes lock. dout_sof=1 on boundary words only.
//    The word that causes loss of lock is not output (dout_valid=0).
//  - A boundary mismatch in LOCKED that does not drop lock still outputs, sof=1.
//  - din_valid==0: state, counters, prev hold; dout_valid=0, dout holds.
//  - locked/offset update in the same edge as the state change.
//  - Reset mid-operation: all of the above cleared on that edge, no partial frame out.
// CONFIGURATION
//  SERDES_ALIGN_ERR_CNT_EN defined: err_cnt increments by 1 on every boundary
//   mismatch while LOCKED, saturating at 16'hFFFF. Cleared only by reset;
//   survives loss/reacquire of lock.
//  Not defined: err_cnt tied to 16'h0000; counter logic not built.
// TESTING (FRAME_LEN=4, LOCK_CNT=3, LOSS_CNT=2, SYNC_WORD default)
//  1 Reset held, random din, din_valid=1 -> all outputs 0, locked=0 throughout.
//  2 Aligned frames {F6F62828,11111111,22222222,33333333}x4 -> locked=1 on 3rd sync,
//    offset=0, dout_sof=1 with dout=F6F62828, payload out unchanged, 1-cycle latency.
//  3 Same stream slipped by 5 bits -> offset=5, dout reproduces the unslipped words.
//  4 Locked; corrupt one sync -> locked stays 1, err_cnt=1 (macro on) / 0 (off);
//    corrupt two consecutive syncs -> locked=0 at second, dout_valid=0 on it.
//  5 Payload word equals SYNC_WORD during HUNT, next boundary wrong -> CONFIRM
//    falls back to HUNT, no dout_valid; true frames then lock normally.
//  6 din_valid toggling 1/0 while locked -> alignment unaffected, dout_valid only
//    after valid words; rst=0 mid-frame -> all outputs 0 next cycle, re-lock from HUNT.

Source files
------------

// File: rtl/serdes_frame_aligner.sv
// Frame aligner: hunts SYNC_WORD at any of 32 bit offsets in the recovered word stream and emits aligned words.
// Optional sync-miss counter is built when SERDES_ALIGN_ERR_CNT_EN is defined.
module serdes_frame_aligner #(
  parameter logic [31:0] SYNC_WORD = 32'hF6F6_2828,
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned LOCK_CNT  = 3,
  parameter int unsigned LOSS_CNT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] din,
  input  logic        din_valid,
  output logic [31:0] dout,
  output logic        dout_valid,
  output logic        dout_sof,
  output logic        locked,
  output logic [4:0]  offset,
  output logic [15:0] err_cnt
);

  localparam int unsigned WC_W   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned HIT_W  = $clog2(LOCK_CNT + 1);
  localparam int unsigned MISS_W = $clog2(LOSS_CNT + 1);
  localparam logic [WC_W-1:0]   WC_LAST   = WC_W'(FRAME_LEN - 1);
  localparam logic [HIT_W-1:0]  HITS_LAST = HIT_W'(LOCK_CNT - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_CNT - 1);

  typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} state_t;

  state_t              state_q, state_d;
  logic [31:0]         prev_q, prev_d;
  logic                prev_ok_q, prev_ok_d;
  logic [WC_W-1:0]     wc_q, wc_d, wc_next;
  logic [HIT_W-1:0]    hits_q, hits_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic [4:0]          offset_q, offset_d;
  logic [31:0]         dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;
  logic                sof_q, sof_d;

  logic [63:0]         win;
  logic [31:0]         cand_off;
  logic                boundary;
  logic                sync_ok;
  logic                hunt_hit;
  logic [4:0]          hunt_k;

  assign win      = {prev_q, din};
  assign cand_off = win[offset_q +: 32];
  assign boundary = (wc_q == '0);
  assign sync_ok  = (cand_off == SYNC_WORD);
  assign wc_next  = (wc_q == WC_LAST) ? '0 : wc_q + WC_W'(1);

  // Lowest matching offset wins.
  always_comb begin
    hunt_hit = 1'b0;
    hunt_k   = '0;
    for (int unsigned k = 0; k < 32; k++) begin
      if (!hunt_hit && win[k +: 32] == SYNC_WORD) begin
        hunt_hit = 1'b1;
        hunt_k   = 5'(k);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    prev_ok_d    = prev_ok_q;
    wc_d         = wc_q;
    hits_d       = hits_q;
    miss_d       = miss_q;
    offset_d     = offset_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    sof_d        = 1'b0;
    if (din_valid) begin
      prev_d    = din;
      prev_ok_d = 1'b1;
      if (prev_ok_q) begin
        case (state_q)
          HUNT: begin
            if (hunt_hit) begin
              offset_d = hunt_k;
              wc_d     = WC_W'(1);
              hits_d   = HIT_W'(1);
              miss_d   = '0;
              if (LOCK_CNT == 1) begin
                state_d      = LOCKED;
                dout_d       = win[hunt_k +: 32];
                dout_valid_d = 1'b1;
                sof_d        = 1'b1;
              end else begin
                state_d = CONFIRM;
              end
            end
          end
          CONFIRM: begin
            wc_d = wc_next;
            if (boundary) begin
              if (sync_ok) begin
                hits_d = hits_q + HIT_W'(1);
                if (hits_q == HITS_LAST) begin
                  state_d      = LOCKED;
                  miss_d       = '0;
                  dout_d       = cand_off;
                  dout_valid_d = 1'b1;
                  sof_d        = 1'b1;
                end
              end else begin
                state_d = HUNT;
                hits_d  = '0;
              end
            end
          end
          LOCKED: begin
            wc_d = wc_next;
            if (boundary && !sync_ok && miss_q == MISS_LAST) begin
              // Losing word is swallowed; dout keeps its last value.
              state_d = HUNT;
              miss_d  = '0;
              hits_d  = '0;
            end else begin
              if (boundary) miss_d = sync_ok ? '0 : miss_q + MISS_W'(1);
              dout_d       = cand_off;
              dout_valid_d = 1'b1;
              sof_d        = boundary;
            end
          end
          default: state_d = HUNT;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= HUNT;
      prev_q       <= '0;
      prev_ok_q    <= 1'b0;
      wc_q         <= '0;
      hits_q       <= '0;
      miss_q       <= '0;
      offset_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sof_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      prev_ok_q    <= prev_ok_d;
      wc_q         <= wc_d;
      hits_q       <= hits_d;
      miss_q       <= miss_d;
      offset_q     <= offset_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      sof_q        <= sof_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_sof   = sof_q;
  assign locked     = (state_q == LOCKED);
  assign offset     = offset_q;

`ifdef SERDES_ALIGN_ERR_CNT_EN
  logic        err_inc;
  logic [15:0] err_q;

  assign err_inc = din_valid && prev_ok_q && (state_q == LOCKED) && boundary && !sync_ok;

  always_ff @(posedge clk) begin
    if (!rst)                        err_q <= '0;
    else if (err_inc && err_q != '1) err_q <= err_q + 16'd1;
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_serdes_frame_aligner.sv
// Directed bench for serdes_frame_aligner with FRAME_LEN=4, LOCK_CNT=3, LOSS_CNT=2.
module tb_serdes_frame_aligner;

  localparam logic [31:0] SYNC = 32'hF6F6_2828;
`ifdef SERDES_ALIGN_ERR_CNT_EN
  localparam logic [15:0] ERR1 = 16'd1;
  localparam logic [15:0] ERR3 = 16'd3;
`else
  localparam logic [15:0] ERR1 = 16'd0;
  localparam logic [15:0] ERR3 = 16'd0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic        din_valid;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_sof;
  logic        locked;
  logic [4:0]  offset;
  logic [15:0] err_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serdes_frame_aligner #(
    .SYNC_WORD (SYNC),
    .FRAME_LEN (4),
    .LOCK_CNT  (3),
    .LOSS_CNT  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_sof   (dout_sof),
    .locked     (locked),
    .offset     (offset),
    .err_cnt    (err_cnt)
  );

  // Aligned stream: index 0 is a filler word, then frames {SYNC,1..,2..,3..}.
  function automatic logic [31:0] aw(input int idx);
    if (idx <= 0) return 32'h0;
    case ((idx - 1) % 4)
      0:       return SYNC;
      1:       return 32'h1111_1111;
      2:       return 32'h2222_2222;
      default: return 32'h3333_3333;
    endcase
  endfunction

  task automatic step(input logic [31:0] d, input logic v);
    @(negedge clk);
    din       = d;
    din_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step($urandom, 1'b1);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step($urandom, 1'b1);
      vectors++;
      if ({dout, dout_valid, dout_sof, locked, offset, err_cnt} !== '0) begin
        miscompares++;
        $display("FAIL reset_%0d dout=%h v=%b sof=%b lk=%b off=%0d err=%0d required all zero",
                 i, dout, dout_valid, dout_sof, locked, offset, err_cnt);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_aligned();
    do_reset();
    for (int i = 0; i <= 16; i++) begin
      step(aw(i), 1'b1);
      vectors++;
      if (locked !== (i >= 9) || dout_valid !== (i >= 9)) begin
        miscompares++;
        $display("FAIL aligned_lock_%0d locked=%b valid=%b required %b", i, locked, dout_valid, i >= 9);
      end
      if (i >= 9) begin
        vectors++;
        if (dout !== aw(i) || dout_sof !== ((i - 1) % 4 == 0)) begin
          miscompares++;
          $display("FAIL aligned_data_%0d dout=%h sof=%b required %h sof=%b",
                   i, dout, dout_sof, aw(i), (i - 1) % 4 == 0);
        end
      end
    end
    vectors++;
    if (offset !== 5'd0) begin
      miscompares++;
      $display("FAIL aligned_offset offset=%0d required 0", offset);
    end
  endtask

  task automatic test_slip();
    logic [31:0] tp, tc, exp_w;
    logic [63:0] cat;
    do_reset();
    for (int n = 0; n <= 17; n++) begin
      tp  = (n == 0) ? 32'h0 : aw(n - 1);
      tc  = (n > 16) ? 32'h0 : aw(n);
      cat = {tp, tc} >> 27;
      step(cat[31:0], 1'b1);
      vectors++;
      if (locked !== (n >= 10) || dout_valid !== (n >= 10)) begin
        miscompares++;
        $display("FAIL slip_lock_%0d locked=%b valid=%b required %b", n, locked, dout_valid, n >= 10);
      end
      if (n >= 10) begin
        exp_w = aw(n - 1);
        vectors++;
        if (dout !== exp_w || dout_sof !== ((n - 2) % 4 == 0) || offset !== 5'd5) begin
          miscompares++;
          $display("FAIL slip_data_%0d dout=%h sof=%b off=%0d required %h sof=%b off=5",
                   n, dout, dout_sof, offset, exp_w, (n - 2) % 4 == 0);
        end
      end
    end
  endtask

  task automatic test_loss();
    logic [31:0] w;
    logic        exp_lk;
    do_reset();
    for (int i = 0; i <= 30; i++) begin
      w      = (i == 17 || i == 25 || i == 29) ? 32'h0 : aw(i);
      exp_lk = (i >= 9 && i < 29);
      step(w, 1'b1);
      vectors++;
      if (locked !== exp_lk || dout_valid !== exp_lk) begin
        miscompares++;
        $display("FAIL loss_lock_%0d locked=%b valid=%b required %b", i, locked, dout_valid, exp_lk);
      end
      if (exp_lk) begin
        vectors++;
        if (dout !== w || dout_sof !== ((i - 1) % 4 == 0)) begin
          miscompares++;
          $display("FAIL loss_data_%0d dout=%h sof=%b required %h sof=%b",
                   i, dout, dout_sof, w, (i - 1) % 4 == 0);
        end
      end
      if (i == 17) begin
        vectors++;
        if (err_cnt !== ERR1) begin
          miscompares++;
          $display("FAIL loss_err1 err_cnt=%0d required %0d", err_cnt, ERR1);
        end
      end
      if (i == 29) begin
        vectors++;
        if (err_cnt !== ERR3) begin
          miscompares++;
          $display("FAIL loss_err3 err_cnt=%0d required %0d", err_cnt, ERR3);
        end
      end
    end
  endtask

  task automatic test_false_sync();
    logic [31:0] pre [0:6];
    logic [31:0] w;
    pre[0] = 32'h0;         pre[1] = 32'h1111_1111; pre[2] = SYNC;
    pre[3] = 32'h2222_2222; pre[4] = 32'h3333_3333; pre[5] = 32'h1111_11F6;
    pre[6] = 32'hF628_2800;
    do_reset();
    for (int i = 0; i <= 18; i++) begin
      w = (i <= 6) ? pre[i] : aw(i - 6);
      step(w, 1'b1);
      vectors++;
      if (locked !== (i >= 15) || dout_valid !== (i >= 15)) begin
        miscompares++;
        $display("FAIL fsync_lock_%0d locked=%b valid=%b required %b", i, locked, dout_valid, i >= 15);
      end
      if (i >= 15) begin
        vectors++;
        if (dout !== w || dout_sof !== ((i - 7) % 4 == 0) || offset !== 5'd0) begin
          miscompares++;
          $display("FAIL fsync_data_%0d dout=%h sof=%b off=%0d required %h sof=%b off=0",
                   i, dout, dout_sof, offset, w, (i - 7) % 4 == 0);
        end
      end
    end
  endtask

  task automatic test_valid_toggle();
    do_reset();
    for (int vi = 0; vi <= 14; vi++) begin
      step(aw(vi), 1'b1);
      vectors++;
      if (locked !== (vi >= 9) || dout_valid !== (vi >= 9) || (vi >= 9 && dout !== aw(vi))) begin
        miscompares++;
        $display("FAIL toggle_valid_%0d locked=%b valid=%b dout=%h required %b %h",
                 vi, locked, dout_valid, dout, vi >= 9, aw(vi));
      end
      step($urandom, 1'b0);
      vectors++;
      if (dout_valid !== 1'b0 || locked !== (vi >= 9) || (vi >= 9 && dout !== aw(vi))) begin
        miscompares++;
        $display("FAIL toggle_idle_%0d locked=%b valid=%b dout=%h required lk=%b valid=0 %h",
                 vi, locked, dout_valid, dout, vi >= 9, aw(vi));
      end
    end
    rst = 1'b0;
    step($urandom, 1'b1);
    rst = 1'b1;
    vectors++;
    if ({dout, dout_valid, dout_sof, locked, offset, err_cnt} !== '0) begin
      miscompares++;
      $display("FAIL midreset dout=%h v=%b sof=%b lk=%b off=%0d err=%0d required all zero",
               dout, dout_valid, dout_sof, locked, offset, err_cnt);
    end
    for (int i = 0; i <= 12; i++) begin
      step(aw(i), 1'b1);
      vectors++;
      if (locked !== (i >= 9) || dout_valid !== (i >= 9)) begin
        miscompares++;
        $display("FAIL relock_%0d locked=%b valid=%b required %b", i, locked, dout_valid, i >= 9);
      end
    end
  endtask

  initial begin
    rst       = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    test_reset();
    test_aligned();
    test_slip();
    test_loss();
    test_false_sync();
    test_valid_toggle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
